key_input_conditioner: RTL and testbench

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

---
 rtl/key_input_conditioner_pkg.sv | 14 +
 rtl/key_input_conditioner_key_debounce.sv | 59 +++++
 rtl/key_input_conditioner.sv | 105 ++++++++++
 tb/tb_key_input_conditioner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/key_input_conditioner_pkg.sv
// Shared constants and the capture-state type for the key/switch input conditioner.
package key_input_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int NUM_KEYS = 4;
  localparam int SW_W     = 16;
  localparam int KEY_LOAD = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_t;

endpackage

// File: rtl/key_input_conditioner_key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, debounced level and
// single-cycle press/release pulses that coincide with the level change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_sample;
  logic             w_differ;
  logic             w_done;

  // Synchronizer holds the raw active-low value; released state is 1.
  assign w_sample = ~r_sync[1];
  assign w_differ = w_sample ^ r_level;
  assign w_done   = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt     <= '0;
        r_level   <= w_sample;
        r_press   <= w_sample;
        r_release <= ~w_sample;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_input_conditioner.sv
// Debounces four pushbuttons and captures the synchronized switch word on a
// press of the load key, handing it to a valid/ready consumer.
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LOAD_KEY        = KEY_LOAD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [SW_W-1:0]     sw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [SW_W-1:0]     data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                overrun
);

  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .clk       (clk),
        .reset     (reset),
        .i_key_n   (key_n[gi]),
        .o_level   (w_level[gi]),
        .o_press   (w_press[gi]),
        .o_release (w_release[gi])
      );
    end
  endgenerate

  assign key_level   = w_level;
  assign key_press   = w_press;
  assign key_release = w_release;

  logic [SW_W-1:0] r_sw_meta;
  logic [SW_W-1:0] r_sw_sync;
  cap_state_t      r_state;
  cap_state_t      w_state_next;
  logic [SW_W-1:0] r_data;
  logic            r_overrun;
  logic            w_load;
  logic            w_set_overrun;
  logic            w_load_press;

  assign w_load_press = w_press[LOAD_KEY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_state   <= IDLE;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_state   <= w_state_next;
      if (w_load)
        r_data <= r_sw_sync;
      if (w_set_overrun)
        r_overrun <= 1'b1;
    end
  end

  // A press arriving while a word is still pending is dropped unless the
  // consumer takes the old word in that same cycle.
  always_comb begin
    w_state_next  = r_state;
    w_load        = 1'b0;
    w_set_overrun = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load_press) begin
          w_load       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_load_press && data_ready) begin
          w_load = 1'b1;
        end else if (w_load_press) begin
          w_set_overrun = 1'b1;
        end else if (data_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign data_out   = r_data;
  assign data_valid = (r_state == HOLD);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES = 4.
// Edge 1 is the edge that first samples a raw change; level moves on edge 6.
module tb_key_input_conditioner;

  logic        clk;
  logic        reset;
  logic [3:0]  key_n;
  logic [15:0] sw;
  logic [3:0]  key_level;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LOAD_KEY       (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .sw          (sw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press and release the load key; the capture happens on edge 7.
  task automatic press_load();
    key_n[1] = 1'b0;
    tick(7);
    key_n[1] = 1'b1;
    tick(8);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  logic seen;

  initial begin
    reset      = 1'b1;
    key_n      = 4'hF;
    sw         = 16'h0000;
    data_ready = 1'b0;
    #1;
    check("rst_level", 32'(key_level), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Key 0 press: nothing through edge 5, level and pulse on edge 6.
    key_n[0] = 1'b0;
    tick(5);
    check("k0_e5_level", 32'(key_level[0]), 32'h0);
    check("k0_e5_press", 32'(key_press[0]), 32'h0);
    tick(1);
    check("k0_e6_level", 32'(key_level[0]), 32'h1);
    check("k0_e6_press", 32'(key_press[0]), 32'h1);
    check("k0_others", 32'(key_level[3:1]), 32'h0);
    tick(1);
    check("k0_e7_press", 32'(key_press[0]), 32'h0);
    check("k0_e7_level", 32'(key_level[0]), 32'h1);
    tick(3);
    key_n[0] = 1'b1;
    tick(5);
    check("k0_rel_e5", 32'(key_release[0]), 32'h0);
    tick(1);
    check("k0_rel_e6_level", 32'(key_level[0]), 32'h0);
    check("k0_rel_e6_pulse", 32'(key_release[0]), 32'h1);
    tick(1);
    check("k0_rel_e7_pulse", 32'(key_release[0]), 32'h0);

    // Key 2 glitch of two cycles must be ignored.
    seen = 1'b0;
    key_n[2] = 1'b0;
    tick(2);
    key_n[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | key_level[2] | key_press[2] | key_release[2];
    end
    check("k2_glitch", 32'(seen), 32'h0);

    // Key 3 press in IDLE updates key 3 only, no capture.
    key_n[3] = 1'b0;
    tick(7);
    check("k3_level", 32'(key_level[3]), 32'h1);
    check("k3_no_capture", 32'(data_valid), 32'h0);
    key_n[3] = 1'b1;
    tick(8);

    // Capture then overrun with the consumer stalled.
    sw = 16'h1234;
    tick(3);
    press_load();
    check("cap1_valid", 32'(data_valid), 32'h1);
    check("cap1_data", 32'(data_out), 32'h1234);
    check("cap1_overrun", 32'(overrun), 32'h0);
    sw = 16'hBEEF;
    press_load();
    check("ovr_data", 32'(data_out), 32'h1234);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_valid", 32'(data_valid), 32'h1);

    // Press and ready in the same cycle replaces the word without overrun.
    do_reset();
    sw = 16'h1234;
    tick(3);
    press_load();
    sw = 16'h00FF;
    tick(3);
    key_n[1] = 1'b0;
    tick(6);
    check("same_press_pulse", 32'(key_press[1]), 32'h1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    check("same_data", 32'(data_out), 32'h00FF);
    check("same_valid", 32'(data_valid), 32'h1);
    check("same_overrun", 32'(overrun), 32'h0);
    key_n[1] = 1'b1;
    tick(8);

    // Ready alone drains HOLD; ready in IDLE is ignored.
    data_ready = 1'b1;
    tick(1);
    check("drain_valid", 32'(data_valid), 32'h0);
    check("drain_data", 32'(data_out), 32'h00FF);
    tick(1);
    data_ready = 1'b0;
    check("idle_ready_valid", 32'(data_valid), 32'h0);
    check("idle_ready_overrun", 32'(overrun), 32'h0);

    // Reset while in HOLD with overrun and the load key mid-debounce.
    sw = 16'h1234;
    press_load();
    sw = 16'hBEEF;
    press_load();
    check("pre_rst_overrun", 32'(overrun), 32'h1);
    key_n[1] = 1'b0;
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 32'(data_valid), 32'h0);
    check("async_overrun", 32'(overrun), 32'h0);
    check("async_data", 32'(data_out), 32'h0);
    check("async_keys", 32'({key_level, key_press, key_release}), 32'h0);
    @(posedge clk);
    tick(1);
    reset = 1'b0;
    tick(5);
    check("post_rst_e5_press", 32'(key_press[1]), 32'h0);
    tick(1);
    check("post_rst_e6_press", 32'(key_press[1]), 32'h1);
    check("post_rst_e6_level", 32'(key_level[1]), 32'h1);
    tick(1);
    check("post_rst_capture", 32'(data_out), 32'hBEEF);
    check("post_rst_valid", 32'(data_valid), 32'h1);
    check("post_rst_overrun", 32'(overrun), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
